vga_pixel_sink: RTL and testbench
=================================

# vga_pixel_sink

Consumer end of the pixel-plot interface driven by the pipeline drawer and other on-screen drawers. Accepts (x, y, color) plot requests through a valid/ready handshake and buffers them in a small FIFO. Translates each request into a linear frame-buffer write and signals frame completion once the drawer's `done` has been seen and every buffered pixel has been written. Sits between the drawers and the VGA frame-buffer memory write port.

## Interface
- `H_RES`, 640, visible pixels per line.
- `V_RES`, 480, visible lines.
- `COLOR_BITS`, 9, pixel color width (3:3:3).
- `FIFO_DEPTH`, 8, request FIFO entries; must be a power of 2, at least 2.
- `ADDR_WIDTH`, 19, frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ H_RES·V_RES.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pixel_x` in 10: column.
- `pixel_y` in 9: row.
- `pixel_color` in COLOR_BITS: color.
- `pixel_valid` in 1: request present.
- `pixel_ready` out 1: sink can accept.
- `draw_done` in 1: drawer's done level.
- `fb_addr` out ADDR_WIDTH: write address.
- `fb_data` out COLOR_BITS: write data.
- `fb_we` out 1: write strobe.
- `fb_ready` in 1: memory accepts the write this cycle.
- `frame_done` out 1: one-cycle completion pulse.
- `busy` out 1: FIFO or write stage occupied, or commit pending.
- `clip_count` out 16: dropped-pixel count. Present only with `VGA_PIXEL_SINK_CLIP_COUNT_EN`.

## Operation
- **Push:** occurs when `pixel_valid && pixel_ready`. `pixel_ready = !fifo_full`, purely registered state with no combinational path from `pixel_valid`.
- **Write stage:** a single register holding {addr, data, valid}. It is loaded from the FIFO head when the FIFO is non-empty and the stage is empty or retiring (`fb_we && fb_ready`).
- **Address:** `fb_addr = y*H_RES + x`, computed at width ADDR_WIDTH with no truncation for in-range coordinates.
- **Clipping:** a head entry with x ≥ H_RES or y ≥ V_RES is popped but never loaded into the write stage. It is dropped and counted as clipped.
- **Write stall:** `fb_we` equals the stage's valid bit. `fb_addr`/`fb_data` are held stable while `fb_we && !fb_ready`.
- **Commit FSM:**
  - IDLE → ARMED on a rising edge of `draw_done`, detected via a registered previous value.
  - ARMED → IDLE when the FIFO is empty and the stage is empty. `frame_done` pulses high for exactly one cycle on that transition.
  - A further `draw_done` edge while ARMED is absorbed; there is no second pulse.
- **Simultaneous push and pop:** allowed; occupancy stays unchanged, and full and empty flags stay correct.
- **Simultaneous last write and new push while ARMED:** the FSM stays ARMED until the new pixel is written.

## Timing
- **Reset values:** `pixel_ready`=1 (FIFO empty), `fb_we`=0, `fb_addr`=0, `fb_data`=0, `frame_done`=0, `busy`=0, `clip_count`=0. FSM=IDLE; FIFO pointers are zero.
- **Reset mid-operation:** FIFO contents, the write stage and the pending commit are discarded. No `frame_done` is issued for the aborted frame.
- **Latency:** a pixel accepted at edge k (empty FIFO, `fb_ready`=1) has `fb_we`=1 during the cycle after edge k+1. Its write completes at edge k+2.
- **Throughput:** one pixel per cycle sustained while `fb_ready`=1.
- **Capacity:** FIFO_DEPTH + 1 pixels are accepted with `fb_ready` held low. `pixel_ready` drops in the cycle after the FIFO fills.
- **Commit timing:** `frame_done` is asserted in the cycle after the edge at which the last write retired and all buffers are empty. With nothing buffered, it is asserted two cycles after the `draw_done` rising edge.

## Configuration
- `VGA_PIXEL_SINK_CLIP_COUNT_EN` defined:
  - `clip_count` port exists.
  - Increments by 1 for each clipped pop.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent. Clipped pixels are still silently dropped.

## Test plan
- **Single pixel:** push (5, 3, 9'h1FF) with `fb_ready`=1 → `fb_we` for one cycle with `fb_addr`=1925 and `fb_data`=9'h1FF, two edges after acceptance.
- **Corner and clipping:**
  - Push (639, 479, 9'h0AA) → `fb_addr`=307199.
  - Push (640, 0) → no `fb_we`; `clip_count`=1.
  - Push (0, 480) → no `fb_we`; `clip_count`=2.
- **Backpressure:** hold `fb_ready`=0 and stream 12 pixels.
  - Exactly 9 are accepted, then `pixel_ready`=0.
  - `fb_addr` is held stable.
  - Release `fb_ready` → 12 writes in order with no loss or duplicate.
- **Commit:** queue 3 pixels, raise `draw_done` → `frame_done` pulses once, one cycle after the third write retires. Hold `draw_done` high afterwards → no further pulse.
- **Empty commit:** `draw_done` rises with nothing queued → `frame_done` two cycles later, `busy` low afterwards.
- **Reset mid-frame:** 5 pixels queued and ARMED, pulse `resetn` low → all outputs return to reset values. No `fb_we` or `frame_done` follows.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// Pixel-plot sink: buffers (x, y, color) requests, writes them to the frame buffer and reports frame completion.
// Optional dropped-pixel counter port clip_count is built when VGA_PIXEL_SINK_CLIP_COUNT_EN is defined.
module vga_pixel_sink #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int COLOR_BITS = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [9:0]            pixel_x,
    input  logic [8:0]            pixel_y,
    input  logic [COLOR_BITS-1:0] pixel_color,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic                  draw_done,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [COLOR_BITS-1:0] fb_data,
    output logic                  fb_we,
    input  logic                  fb_ready,
    output logic                  frame_done,
    output logic                  busy
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    ,
    output logic [15:0]           clip_count
`endif
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 10 + 9 + COLOR_BITS;
    localparam logic [PTR_W:0] FIFO_FULL_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] PTR_ONE       = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_t;

    logic [ENTRY_W-1:0]    r_fifo_mem_p0 [FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr_p0;
    logic [PTR_W:0]        r_rd_ptr_p0;

    logic [ADDR_WIDTH-1:0] r_stage_addr_p1;
    logic [COLOR_BITS-1:0] r_stage_data_p1;
    logic                  r_stage_vld_p1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_done_prev;
    logic                  r_frame_done;
    logic                  w_frame_done_nxt;

    logic [PTR_W:0]        w_count;
    logic [PTR_W:0]        w_cnt_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_retire;
    logic                  w_clip;
    logic                  w_load;
    logic                  w_stage_vld_nxt;
    logic                  w_drained_nxt;
    logic                  w_done_rise;
    logic [ENTRY_W-1:0]    w_head;
    logic [9:0]            w_head_x;
    logic [8:0]            w_head_y;
    logic [COLOR_BITS-1:0] w_head_c;
    logic [ADDR_WIDTH-1:0] w_head_addr;

    // Stage p0: request FIFO
    assign w_count  = r_wr_ptr_p0 - r_rd_ptr_p0;
    assign w_full   = (w_count == FIFO_FULL_CNT);
    assign w_empty  = (w_count == '0);
    assign w_push   = pixel_valid && !w_full;
    assign w_retire = r_stage_vld_p1 && fb_ready;
    assign w_pop    = !w_empty && (!r_stage_vld_p1 || w_retire);

    assign w_head      = r_fifo_mem_p0[r_rd_ptr_p0[PTR_W-1:0]];
    assign w_head_x    = w_head[ENTRY_W-1 -: 10];
    assign w_head_y    = w_head[COLOR_BITS +: 9];
    assign w_head_c    = w_head[COLOR_BITS-1:0];
    assign w_clip      = (int'(w_head_x) >= H_RES) || (int'(w_head_y) >= V_RES);
    assign w_load      = w_pop && !w_clip;
    assign w_head_addr = ADDR_WIDTH'(w_head_y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(w_head_x);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem_p0[r_wr_ptr_p0[PTR_W-1:0]] <= {pixel_x, pixel_y, pixel_color};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr_p0 <= '0;
            r_rd_ptr_p0 <= '0;
        end else begin
            if (w_push) r_wr_ptr_p0 <= r_wr_ptr_p0 + PTR_ONE;
            if (w_pop)  r_rd_ptr_p0 <= r_rd_ptr_p0 + PTR_ONE;
        end
    end

    // Stage p1: write stage, held while memory stalls
    assign w_stage_vld_nxt = w_load || (r_stage_vld_p1 && !fb_ready);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stage_vld_p1  <= 1'b0;
            r_stage_addr_p1 <= '0;
            r_stage_data_p1 <= '0;
        end else begin
            r_stage_vld_p1 <= w_stage_vld_nxt;
            if (w_load) begin
                r_stage_addr_p1 <= w_head_addr;
                r_stage_data_p1 <= w_head_c;
            end
        end
    end

    // Commit looks ahead at post-edge occupancy so the pulse lands right after the last retire
    assign w_cnt_nxt     = w_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    assign w_drained_nxt = (w_cnt_nxt == '0) && !w_stage_vld_nxt;
    assign w_done_rise   = draw_done && !r_done_prev;

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_done_rise) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_drained_nxt) begin
                    w_state_nxt      = S_IDLE;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A done level held across reset is not treated as a fresh edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_done_prev  <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_prev  <= draw_done;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign pixel_ready = !w_full;
    assign fb_we       = r_stage_vld_p1;
    assign fb_addr     = r_stage_addr_p1;
    assign fb_data     = r_stage_data_p1;
    assign frame_done  = r_frame_done;
    assign busy        = !w_empty || r_stage_vld_p1 || (r_state == S_ARMED);

`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    logic [15:0] r_clip_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clip_count <= '0;
        end else if (w_pop && w_clip) begin
            r_clip_count <= sat_inc16(r_clip_count);
        end
    end

    assign clip_count = r_clip_count;
`else
    // Clipped pops simply never reach the write stage.
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Scoreboard bench for vga_pixel_sink: random and directed plots checked against a coordinate-level model.
module tb_vga_pixel_sink;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int COLOR_BITS = 9;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_WIDTH = 19;

    logic                  clock;
    logic                  resetn;
    logic [9:0]            pixel_x;
    logic [8:0]            pixel_y;
    logic [COLOR_BITS-1:0] pixel_color;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  draw_done;
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic [COLOR_BITS-1:0] fb_data;
    logic                  fb_we;
    logic                  fb_ready;
    logic                  frame_done;
    logic                  busy;
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
    logic [15:0]           clip_count;
`endif

    vga_pixel_sink #(
        .H_RES(H_RES), .V_RES(V_RES), .COLOR_BITS(COLOR_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clock(clock), .resetn(resetn),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .draw_done(draw_done),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
        .frame_done(frame_done), .busy(busy)
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
        , .clip_count(clip_count)
`endif
    );

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_we_cyc = -1;
    int fd_count = 0;
    int fd_last_cyc = -1;
    int exp_clip = 0;
    logic                  prev_stall = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr = '0;
    logic [COLOR_BITS-1:0] prev_data = '0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a plot request either lands at y*H_RES+x or is counted as clipped.
    task automatic model_accept(input int x, input int y, input int c);
        exp_t e;
        if (x >= H_RES || y >= V_RES) begin
            exp_clip++;
        end else begin
            e.addr = y * H_RES + x;
            e.data = c;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: retires scoreboard entries and watches stall stability and frame_done pulses.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_we_held", fb_we, 1);
                check("stall_addr_held", fb_addr, prev_addr);
                check("stall_data_held", fb_data, prev_data);
            end
            if (fb_we && fb_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", fb_addr, fb_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", fb_addr, mon_e.addr);
                    check("wr_data", fb_data, mon_e.data);
                end
                wr_count++;
                last_we_cyc = cyc;
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
            if (frame_done) begin
                fd_count++;
                fd_last_cyc = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_ready"}, pixel_ready, 1);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
        check({tag, "_clip_count"}, clip_count, 0);
`endif
    endtask

    task automatic drive_pix(input int x, input int y, input int c);
        pixel_x     = x[9:0];
        pixel_y     = y[8:0];
        pixel_color = c[COLOR_BITS-1:0];
    endtask

    // Called and returns just after a rising edge.
    task automatic send_pixel(input int x, input int y, input int c, output int acc_cyc);
        bit accepted;
        accepted = 0;
        acc_cyc  = -1;
        drive_pix(x, y, c);
        pixel_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!accepted) begin
                @(negedge clock);
                if (pixel_ready) begin
                    model_accept(x, y, c);
                    acc_cyc  = cyc;
                    accepted = 1;
                end
                @(posedge clock);
                #1;
            end
        end
        pixel_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got pixel_ready=0 for 100 cycles, expected acceptance");
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound; i++) begin
            if (!done) begin
                @(negedge clock);
                done = (exp_q.size() == 0) && !busy;
            end
        end
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_pending"}, exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int acc;
    int w0;
    int f0;
    int idx;
    int inrange;
    int rx;
    int ry;
    int rc;
    int bx[12];
    int by[12];
    int bc[12];
    int p;

    initial begin
        resetn      = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_color = '0;
        pixel_valid = 1'b0;
        draw_done   = 1'b0;
        fb_ready    = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        idle_cycles(2);

        // Single pixel and latency
        w0 = wr_count;
        send_pixel(5, 3, 'h1FF, acc);
        wait_drain("single", 50);
        check("single_writes", wr_count - w0, 1);
        check("single_latency", last_we_cyc - acc, 2);

        // Corner and clipping
        w0 = wr_count;
        send_pixel(639, 479, 'h0AA, acc);
        send_pixel(640, 0, 'h155, acc);
        send_pixel(0, 480, 'h0F0, acc);
        wait_drain("corner", 50);
        check("corner_writes", wr_count - w0, 1);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
        check("corner_clip_count", clip_count, exp_clip);
`endif

        // Backpressure: capacity is FIFO_DEPTH + 1
        for (int i = 0; i < 12; i++) begin
            bx[i] = $urandom_range(0, H_RES - 1);
            by[i] = $urandom_range(0, V_RES - 1);
            bc[i] = $urandom_range(0, (1 << COLOR_BITS) - 1);
        end
        w0 = wr_count;
        idx = 0;
        fb_ready = 1'b0;
        drive_pix(bx[0], by[0], bc[0]);
        pixel_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (pixel_ready && idx < 12) begin
                model_accept(bx[idx], by[idx], bc[idx]);
                idx++;
            end
            @(posedge clock);
            #1;
            if (idx < 12) drive_pix(bx[idx], by[idx], bc[idx]);
        end
        @(negedge clock);
        check("bp_accepted", idx, FIFO_DEPTH + 1);
        check("bp_ready_low", pixel_ready, 0);
        check("bp_we_held", fb_we, 1);
        check("bp_head_addr", fb_addr, by[0] * H_RES + bx[0]);
        check("bp_no_writes", wr_count - w0, 0);
        @(posedge clock);
        #1;
        fb_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (idx < 12) begin
                @(negedge clock);
                if (pixel_ready) begin
                    model_accept(bx[idx], by[idx], bc[idx]);
                    idx++;
                end
                @(posedge clock);
                #1;
                if (idx < 12) drive_pix(bx[idx], by[idx], bc[idx]);
            end
        end
        pixel_valid = 1'b0;
        check("bp_all_accepted", idx, 12);
        wait_drain("bp", 80);
        check("bp_writes", wr_count - w0, 12);

        // Random traffic with random memory stalls and clipped coordinates
        w0 = wr_count;
        f0 = fd_count;
        inrange = 0;
        for (int n = 0; n < 400; n++) begin
            rx = $urandom_range(0, 719);
            ry = $urandom_range(0, 511);
            rc = $urandom_range(0, (1 << COLOR_BITS) - 1);
            drive_pix(rx, ry, rc);
            pixel_valid = ($urandom_range(0, 3) != 0);
            fb_ready    = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (pixel_valid && pixel_ready) begin
                model_accept(rx, ry, rc);
                if (rx < H_RES && ry < V_RES) inrange++;
            end
            @(posedge clock);
            #1;
        end
        pixel_valid = 1'b0;
        fb_ready = 1'b1;
        wait_drain("rand", 100);
        check("rand_writes", wr_count - w0, inrange);
        check("rand_no_frame_done", fd_count - f0, 0);
`ifdef VGA_PIXEL_SINK_CLIP_COUNT_EN
        check("rand_clip_count", clip_count, exp_clip);
`endif

        // Commit after three queued pixels
        w0 = wr_count;
        f0 = fd_count;
        fb_ready = 1'b0;
        send_pixel(10, 20, 'h011, acc);
        send_pixel(11, 20, 'h022, acc);
        send_pixel(12, 20, 'h033, acc);
        draw_done = 1'b1;
        idle_cycles(4);
        @(negedge clock);
        check("commit_wait_no_pulse", fd_count - f0, 0);
        check("commit_wait_busy", busy, 1);
        @(posedge clock);
        #1;
        fb_ready = 1'b1;
        idle_cycles(30);
        check("commit_writes", wr_count - w0, 3);
        check("commit_pulses", fd_count - f0, 1);
        check("commit_timing", fd_last_cyc - last_we_cyc, 1);
        idle_cycles(10);
        check("commit_no_repeat", fd_count - f0, 1);
        check("commit_busy_low", busy, 0);
        draw_done = 1'b0;
        idle_cycles(3);

        // Empty commit
        f0 = fd_count;
        p = cyc;
        draw_done = 1'b1;
        idle_cycles(6);
        check("empty_commit_pulses", fd_count - f0, 1);
        check("empty_commit_timing", fd_last_cyc - p, 2);
        @(negedge clock);
        check("empty_commit_busy", busy, 0);
        @(posedge clock);
        #1;
        draw_done = 1'b0;
        idle_cycles(3);

        // Reset mid-frame with five pixels queued and commit armed
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_pixel(100 + i, 50, 'h100 + i, acc);
        draw_done = 1'b1;
        idle_cycles(3);
        @(negedge clock);
        check("armed_busy", busy, 1);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        exp_clip = 0;
        @(negedge clock);
        check_reset_outputs("midreset");
        idle_cycles(2);
        resetn = 1'b1;
        fb_ready = 1'b1;
        w0 = wr_count;
        f0 = fd_count;
        idle_cycles(20);
        check("midreset_no_writes", wr_count - w0, 0);
        check("midreset_no_frame_done", fd_count - f0, 0);
        @(negedge clock);
        check("midreset_busy", busy, 0);
        check("midreset_ready", pixel_ready, 1);
        draw_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
